wb_cernbe_bridge: RTL and testbench

// Upstream master for the CERN-BE register bus. Takes 32-bit pipelined Wishbone accesses from the host interconnect.

---
 rtl/wb_cernbe_bridge.sv | 134 +++++++++++++
 tb/tb_wb_cernbe_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cernbe_bridge.sv
// Wishbone (32-bit, pipelined) to CERN-BE (16-bit) bridge: splits each access into
// up to two half-word accesses, upper half first, with a Done timeout.
module wb_cernbe_bridge #(
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:2] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH-1:1] VMEAddr_o,
  output logic [15:0]           VMEWrData_o,
  output logic                  VMERdMem_o,
  output logic                  VMEWrMem_o,
  input  logic [15:0]           VMERdData_i,
  input  logic                  VMERdDone_i,
  input  logic                  VMEWrDone_i
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t                state, state_nxt;
  logic                  we_q, lo_en_q, half_q, abort_q;
  logic [ADDR_WIDTH-1:2] adr_q;
  logic [15:0]           wdat_lo_q, cnt_q, hi_q, lo_q;
  logic                  accept, hi_en, lo_en, busy, done, timeout, aborting, more;
  logic [15:0]           hi_nxt, lo_nxt;

  always_comb begin
    hi_en    = |wb_sel_i[3:2];
    lo_en    = |wb_sel_i[1:0];
    accept   = (state == IDLE) && wb_cyc_i && wb_stb_i;
    busy     = (state == STROBE) || (state == WAIT);
    done     = busy && (we_q ? VMEWrDone_i : VMERdDone_i);
    timeout  = (state == WAIT) && !done && (cnt_q == TIMEOUT_LAST);
    // Once the master drops cyc the access is finished quietly: no second half, no ack/err.
    aborting = abort_q || !wb_cyc_i;
    more     = !half_q && lo_en_q;
    hi_nxt   = (done && !we_q && !half_q) ? VMERdData_i : hi_q;
    lo_nxt   = (done && !we_q && half_q) ? VMERdData_i : lo_q;
  end

  always_comb begin
    state_nxt  = state;
    VMERdMem_o = 1'b0;
    VMEWrMem_o = 1'b0;
    wb_ack_o   = 1'b0;
    wb_err_o   = 1'b0;
    wb_stall_o = 1'b1;
    unique case (state)
      IDLE: begin
        wb_stall_o = !rst_n;
        if (accept) state_nxt = (hi_en || lo_en) ? STROBE : RESP;
      end
      STROBE, WAIT: begin
        if (state == STROBE) begin
          VMERdMem_o = rst_n && !we_q;
          VMEWrMem_o = rst_n && we_q;
        end
        if (done) begin
          state_nxt = aborting ? IDLE : (more ? STROBE : RESP);
        end else if (timeout) begin
          state_nxt = IDLE;
          wb_err_o  = rst_n && !aborting;
        end else begin
          state_nxt = WAIT;
        end
      end
      RESP: begin
        wb_ack_o  = rst_n && !aborting;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      we_q        <= 1'b0;
      lo_en_q     <= 1'b0;
      half_q      <= 1'b0;
      adr_q       <= '0;
      wdat_lo_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      VMEAddr_o   <= '0;
      VMEWrData_o <= '0;
      wb_dat_o    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q        <= wb_we_i;
        adr_q       <= wb_adr_i;
        lo_en_q     <= lo_en;
        half_q      <= !hi_en;
        wdat_lo_q   <= wb_dat_i[15:0];
        abort_q     <= 1'b0;
        hi_q        <= '0;
        lo_q        <= '0;
        VMEAddr_o   <= {wb_adr_i, !hi_en};
        VMEWrData_o <= hi_en ? wb_dat_i[31:16] : wb_dat_i[15:0];
        if (!(hi_en || lo_en)) wb_dat_o <= '0;
      end else if (state != IDLE && !wb_cyc_i) begin
        abort_q <= 1'b1;
      end

      if (state == STROBE)    cnt_q <= '0;
      else if (state == WAIT) cnt_q <= cnt_q + 16'd1;

      if (done) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
        if (!aborting && more) begin
          half_q      <= 1'b1;
          VMEAddr_o   <= {adr_q, 1'b1};
          VMEWrData_o <= wdat_lo_q;
        end
        if (!aborting && !more) wb_dat_o <= {hi_nxt, lo_nxt};
      end
    end
  end
endmodule

// File: tb/tb_wb_cernbe_bridge.sv
// Directed bench for wb_cernbe_bridge: vector table of single accesses plus
// hand-written timeout, reset-mid-access and cyc-drop sequences.
module tb_wb_cernbe_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [0:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_w, wb_dat_r;
  logic        wb_ack, wb_err, wb_stall;
  logic [1:0]  vme_addr;
  logic [15:0] vme_wdata, rd_data;
  logic        vme_rd, vme_wr;
  logic        resp_rd, resp_wr, inj_rd, inj_wr, mute;
  logic [15:0] mem [4];
  int          n_tests, n_fail;

  always #5 clk = ~clk;

  wb_cernbe_bridge #(.ADDR_WIDTH(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
    .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_stall_o(wb_stall),
    .VMEAddr_o(vme_addr), .VMEWrData_o(vme_wdata),
    .VMERdMem_o(vme_rd), .VMEWrMem_o(vme_wr),
    .VMERdData_i(rd_data), .VMERdDone_i(resp_rd | inj_rd), .VMEWrDone_i(resp_wr | inj_wr)
  );

  // Responder: RdDone 1 cycle after RdMem, WrDone 2 cycles after WrMem; mute silences it.
  initial begin
    logic       n_rd, n_wr, w1;
    logic [1:0] n_a, w1a;
    logic [15:0] n_d, w1d;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    resp_rd = 0; resp_wr = 0; rd_data = '0; w1 = 0; w1a = '0; w1d = '0;
    forever begin
      @(negedge clk);
      n_rd = vme_rd; n_wr = vme_wr; n_a = vme_addr; n_d = vme_wdata;
      @(posedge clk); #2;
      resp_rd = n_rd && !mute;
      if (n_rd) rd_data = mem[n_a];
      resp_wr = w1 && !mute;
      if (w1 && !mute) mem[w1a] = w1d;
      w1 = n_wr; w1a = n_a; w1d = n_d;
    end
  end

  typedef struct {
    logic        we;
    logic        adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          nstb;
    int          ack;
    logic [31:0] rdat;
    int          c1;
    logic [1:0]  a0;
    logic [15:0] d0;
    logic [1:0]  a1;
    logic [15:0] d1;
  } vec_t;

  typedef struct {
    int          nstb, ack_k, err_k, c0, c1, unstable;
    logic        t0;
    logic [1:0]  a0, a1;
    logic [15:0] d0, d1;
    logic [31:0] rdat;
  } res_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at posedge+1 of the accept cycle (c0); cycle k = k-th cycle after accept.
  task automatic run_access(input logic we, input logic adr, input logic [3:0] sel,
                            input logic [31:0] dat, output res_t r);
    logic       pending;
    logic [1:0] last_a;
    r = '{nstb: 0, ack_k: -1, err_k: -1, c0: 0, c1: 0, unstable: 0, t0: 0,
          a0: '0, a1: '0, d0: '0, d1: '0, rdat: '0};
    pending = 0; last_a = '0;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
    @(posedge clk); #1;
    wb_stb = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (pending && vme_addr != last_a) r.unstable++;
      if (vme_rd || vme_wr) begin
        if (r.nstb == 0) begin
          r.c0 = k; r.a0 = vme_addr; r.d0 = vme_wdata; r.t0 = vme_rd;
        end else if (r.nstb == 1) begin
          r.c1 = k; r.a1 = vme_addr; r.d1 = vme_wdata;
        end
        r.nstb++;
        pending = 1; last_a = vme_addr;
      end
      if (we ? (resp_wr | inj_wr) : (resp_rd | inj_rd)) pending = 0;
      if (wb_ack) begin r.ack_k = k; r.rdat = wb_dat_r; end
      if (wb_err) r.err_k = k;
      if (wb_ack || wb_err) break;
    end
    @(posedge clk); #1;
    wb_cyc = 0;
  endtask

  initial begin
    res_t r;
    int   cnt_stb, cnt_resp, cnt_stall;
    n_tests = 0; n_fail = 0;
    rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_sel = '0; wb_dat_w = '0;
    inj_rd = 0; inj_wr = 0; mute = 0;

    vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 2, 7, 32'h0,        4, 2'd2, 16'hDEAD, 2'd3, 16'hBEEF};
    vecs[1]  = '{1'b1, 1'b0, 4'hF, 32'h12345678, 2, 7, 32'h0,        4, 2'd0, 16'h1234, 2'd1, 16'h5678};
    vecs[2]  = '{1'b0, 1'b0, 4'hF, 32'h0,        2, 5, 32'h12345678, 3, 2'd0, 16'h0,    2'd1, 16'h0};
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 32'h0,        2, 5, 32'hDEADBEEF, 3, 2'd2, 16'h0,    2'd3, 16'h0};
    vecs[4]  = '{1'b0, 1'b1, 4'h3, 32'h0,        1, 3, 32'h0000BEEF, 0, 2'd3, 16'h0,    2'd0, 16'h0};
    vecs[5]  = '{1'b0, 1'b1, 4'hC, 32'h0,        1, 3, 32'hDEAD0000, 0, 2'd2, 16'h0,    2'd0, 16'h0};
    vecs[6]  = '{1'b0, 1'b0, 4'h4, 32'h0,        1, 3, 32'h12340000, 0, 2'd0, 16'h0,    2'd0, 16'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 32'hFFFFFFFF, 0, 1, 32'h0,        0, 2'd0, 16'h0,    2'd0, 16'h0};
    vecs[8]  = '{1'b1, 1'b0, 4'h1, 32'hFFFFABCD, 1, 4, 32'h0,        0, 2'd1, 16'hABCD, 2'd0, 16'h0};
    vecs[9]  = '{1'b0, 1'b0, 4'hF, 32'h0,        2, 5, 32'h1234ABCD, 3, 2'd0, 16'h0,    2'd1, 16'h0};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 32'h0,        0, 1, 32'h0,        0, 2'd0, 16'h0,    2'd0, 16'h0};
    vecs[11] = '{1'b1, 1'b1, 4'h8, 32'hCAFE0000, 1, 4, 32'h0,        0, 2'd2, 16'hCAFE, 2'd0, 16'h0};
    vecs[12] = '{1'b0, 1'b1, 4'hF, 32'h0,        2, 5, 32'hCAFEBEEF, 3, 2'd2, 16'h0,    2'd3, 16'h0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst stall", 32'(wb_stall), 32'd1);
    check("rst ack", 32'(wb_ack), 32'd0);
    check("rst err", 32'(wb_err), 32'd0);
    check("rst strobes", 32'({vme_rd, vme_wr}), 32'd0);
    check("rst addr", 32'(vme_addr), 32'd0);
    check("rst wdata", 32'(vme_wdata), 32'd0);
    check("rst dat_o", wb_dat_r, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("idle stall", 32'(wb_stall), 32'd0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      run_access(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, r);
      check($sformatf("v%0d ack cycle", i), r.ack_k, vecs[i].ack);
      check($sformatf("v%0d err", i), r.err_k, -1);
      check($sformatf("v%0d strobes", i), r.nstb, vecs[i].nstb);
      check($sformatf("v%0d addr unstable", i), r.unstable, 0);
      if (vecs[i].nstb > 0) begin
        check($sformatf("v%0d strobe0 cycle", i), r.c0, 1);
        check($sformatf("v%0d strobe0 addr", i), 32'(r.a0), 32'(vecs[i].a0));
        check($sformatf("v%0d strobe0 is read", i), 32'(r.t0), 32'(!vecs[i].we));
        if (vecs[i].we) check($sformatf("v%0d strobe0 data", i), 32'(r.d0), 32'(vecs[i].d0));
      end
      if (vecs[i].nstb == 2) begin
        check($sformatf("v%0d strobe1 cycle", i), r.c1, vecs[i].c1);
        check($sformatf("v%0d strobe1 addr", i), 32'(r.a1), 32'(vecs[i].a1));
        if (vecs[i].we) check($sformatf("v%0d strobe1 data", i), 32'(r.d1), 32'(vecs[i].d1));
      end
      if (!vecs[i].we || vecs[i].sel == 4'h0)
        check($sformatf("v%0d dat_o", i), r.rdat, vecs[i].rdat);
    end

    // Timeout with a mute slave, then a late WrDone in IDLE
    mute = 1;
    run_access(1'b1, 1'b0, 4'hF, 32'h11112222, r);
    check("to err cycle", r.err_k, 9);
    check("to ack", r.ack_k, -1);
    check("to strobes", r.nstb, 1);
    cnt_stb = 0; cnt_resp = 0; cnt_stall = 0;
    for (int k = 0; k < 4; k++) begin
      inj_wr = (k == 1);
      @(negedge clk);
      cnt_stb  += int'(vme_rd) + int'(vme_wr);
      cnt_resp += int'(wb_ack) + int'(wb_err);
      cnt_stall += int'(wb_stall);
      @(posedge clk); #1;
    end
    inj_wr = 0;
    check("to no second strobe", cnt_stb, 0);
    check("to late done ignored", cnt_resp, 0);
    check("to back in idle", cnt_stall, 0);
    mute = 0;
    run_access(1'b0, 1'b1, 4'hF, 32'h0, r);
    check("after to ack", r.ack_k, 5);
    check("after to dat_o", r.rdat, 32'hCAFEBEEF);

    // Reset during WAIT of the hi half
    mute = 1;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 1'b0; wb_sel = 4'hF;
    @(posedge clk); #1;
    wb_stb = 0;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid rst strobes", 32'({vme_rd, vme_wr}), 32'd0);
    check("mid rst ack", 32'(wb_ack), 32'd0);
    check("mid rst stall", 32'(wb_stall), 32'd1);
    rst_n = 1; wb_cyc = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post rst idle", 32'(wb_stall), 32'd0);
    @(posedge clk); #1;
    mute = 0;
    run_access(1'b0, 1'b0, 4'hF, 32'h0, r);
    check("post rst ack", r.ack_k, 5);
    check("post rst dat_o", r.rdat, 32'h1234ABCD);

    // cyc dropped right after the hi-half strobe; stray RdDone later
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 1'b1; wb_sel = 4'hF;
    @(posedge clk); #1;
    wb_stb = 0; wb_cyc = 0;
    cnt_stb = 0; cnt_resp = 0; cnt_stall = 1;
    for (int k = 1; k <= 8; k++) begin
      inj_rd = (k == 5);
      @(negedge clk);
      if (k == 1) check("drop strobe addr", 32'(vme_addr), 32'd2);
      if (k == 3) cnt_stall = int'(wb_stall);
      cnt_stb  += int'(vme_rd) + int'(vme_wr);
      cnt_resp += int'(wb_ack) + int'(wb_err);
      @(posedge clk); #1;
    end
    inj_rd = 0;
    check("drop strobes", cnt_stb, 1);
    check("drop no ack/err", cnt_resp, 0);
    check("drop idle after hi", cnt_stall, 0);
    check("drop dat_o held", wb_dat_r, 32'h1234ABCD);
    run_access(1'b0, 1'b0, 4'h3, 32'h0, r);
    check("after drop ack", r.ack_k, 3);
    check("after drop dat_o", r.rdat, 32'h0000ABCD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
